shared_adder_arb: RTL

Round-robin arbiter and sequencer that shares one registered unsigned adder between `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and computes the sum in a single output register. It returns the result tagged with the requester index through a valid/ready response port. It sits between the request sources and the result consumer.

---
 rtl/shared_adder_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/shared_adder_arb.sv
// shared_adder_arb: round-robin arbiter that time-shares one registered
// unsigned adder between N_REQ requesters, returning each result tagged
// with the index of the requester that produced it.
//
// Build option: define SHARED_ADDER_ARB_SAT_EN to make the adder saturate
// at 2^WIDTH-1 (MSB of rsp_sum then always 0). Without it, rsp_sum carries
// the full WIDTH+1-bit sum including the carry.
module shared_adder_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH:0]         rsp_sum,
  output logic [ID_W-1:0]        rsp_id
);

  // Response register occupancy: EMPTY holds nothing, FULL holds a result.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Widest index value reached while searching is last_id + N_REQ, which is
  // below 2*N_REQ and therefore fits in ID_W+1 bits.
  localparam logic [ID_W:0] N_REQ_X = (ID_W+1)'(N_REQ);

  logic [0:0]      r_state;
  logic [WIDTH:0]  r_rsp_sum;
  logic [ID_W-1:0] r_rsp_id;
  logic [ID_W-1:0] r_last_id;

  logic [WIDTH-1:0] w_a_arr [N_REQ];
  logic [WIDTH-1:0] w_b_arr [N_REQ];
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH:0]   w_sum_full;
  logic [WIDTH:0]   w_sum;

  logic [ID_W:0]    w_idx;
  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic             w_can_load;
  logic             w_xfer;

  // Split the flat operand buses into per-requester slices.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search starting one past the last winner, wrapping around;
  // the first requester with valid set wins. Only valids and the pointer
  // feed this path, so ready never depends on operand data.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_last_id} + (ID_W+1)'(k);
      if (w_idx >= N_REQ_X) begin
        w_idx = w_idx - N_REQ_X;
      end
      if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[ID_W-1:0];
      end
    end
  end

  // The response register can accept a new result when it is empty or is
  // being drained this same cycle. Nothing is accepted while reset is held.
  assign w_can_load = (r_state == ST_EMPTY) || rsp_ready;
  assign w_xfer     = w_found && w_can_load && rstn;

  // At most one ready bit, for the current winner.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_xfer && (w_win == ID_W'(gi));
    end
  endgenerate

  // Shared adder fed by the winner's operands.
  assign w_op_a     = w_a_arr[w_win];
  assign w_op_b     = w_b_arr[w_win];
  assign w_sum_full = {1'b0, w_op_a} + {1'b0, w_op_b};

`ifdef SHARED_ADDER_ARB_SAT_EN
  // Clamp to the largest WIDTH-bit value when the carry is set.
  always_comb begin
    if (w_sum_full[WIDTH]) begin
      w_sum = {1'b0, {WIDTH{1'b1}}};
    end else begin
      w_sum = {1'b0, w_sum_full[WIDTH-1:0]};
    end
  end
`else
  // Full-width sum with the carry kept in the MSB.
  always_comb begin
    w_sum = w_sum_full;
  end
`endif

  // Occupancy, result data and round-robin pointer. A transfer reloads the
  // register (even while draining, giving back-to-back results); a drain
  // without a transfer empties it; otherwise everything holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_EMPTY;
      r_rsp_sum <= '0;
      r_rsp_id  <= '0;
      r_last_id <= ID_W'(N_REQ - 1);
    end else begin
      if (w_xfer) begin
        r_state   <= ST_FULL;
        r_rsp_sum <= w_sum;
        r_rsp_id  <= w_win;
        r_last_id <= w_win;
      end else if ((r_state == ST_FULL) && rsp_ready) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;

endmodule
